dma_cmd_queue: RTL

DMA_CMD_QUEUE -- requirements
Module: dma_cmd_queue

---
 rtl/dma_cmd_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dma_cmd_queue.sv
// Command FIFO between the control unit and the DMA engine: filters malformed
// commands, issues one command at a time and counts completions.
module dma_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int CMD_W = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CMD_W-1:0]         in_cmd,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [CMD_W-1:0]         dma_cmd,
   output logic                     dma_cmd_valid,
   input  logic                     dma_cmd_ready,
   input  logic                     dma_cmd_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic [15:0]              done_count,
   output logic                     err,
   input  logic                     err_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   // Only LOAD/STORE of class 03 with a non-empty tile is forwarded.
   function automatic logic cmd_ok(input logic [7:0] cls, input logic [7:0] op,
                                   input logic [11:0] rows, input logic [11:0] cols);
      logic op_ok;
      op_ok = (op == 8'h01) || (op == 8'h02);
      return (cls == 8'h03) && op_ok && (rows != 12'h000) && (cols != 12'h000);
   endfunction

   state_t             state_r;
   state_t             state_s;
   logic [PW-1:0]      wr_ptr_r;
   logic [PW-1:0]      rd_ptr_r;
   logic [CW-1:0]      count_r;
   logic [15:0]        done_count_r;
   logic               err_r;
   logic [CMD_W-1:0]   mem_r [DEPTH];

   logic               accept_s;
   logic               legal_s;
   logic               push_s;
   logic               reject_s;
   logic               pop_s;
   logic               done_hit_s;

   assign in_ready   = (count_r < CW'(DEPTH));
   assign accept_s   = in_valid && in_ready;
   assign legal_s    = cmd_ok(in_cmd[127:120], in_cmd[119:112], in_cmd[51:40], in_cmd[39:28]);
   assign push_s     = accept_s && legal_s;
   assign reject_s   = accept_s && !legal_s;
   assign pop_s      = (state_r == ISSUE) && dma_cmd_ready;
   assign done_hit_s = (state_r == WAIT_DONE) && dma_cmd_done;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; done pulses outside WAIT_DONE fall through unused.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (count_r != {CW{1'b0}}) state_s = ISSUE;
            else                       state_s = IDLE;
         end
         ISSUE: begin
            if (dma_cmd_ready) state_s = WAIT_DONE;
            else               state_s = ISSUE;
         end
         WAIT_DONE: begin
            if (dma_cmd_done) state_s = IDLE;
            else              state_s = WAIT_DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // Pointers, occupancy, completion counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         done_count_r <= 16'h0000;
         err_r        <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         if (done_hit_s) done_count_r <= done_count_r + 16'h0001;
         if (reject_s)     err_r <= 1'b1;
         else if (err_clr) err_r <= 1'b0;
      end
   end

   // Storage array; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (rst_n && push_s) begin
         mem_r[wr_ptr_r] <= in_cmd;
      end
   end

   assign dma_cmd       = (count_r == {CW{1'b0}}) ? {CMD_W{1'b0}} : mem_r[rd_ptr_r];
   assign dma_cmd_valid = (state_r == ISSUE);
   assign busy          = (state_r != IDLE) || (count_r != {CW{1'b0}});
   assign count         = count_r;
   assign done_count    = done_count_r;
   assign err           = err_r;

endmodule
